mips_harvard_data_mem: RTL and testbench

Word-addressed data-memory responder for the Harvard CPU data port. It sits on the other end of data_address/data_read/data_write/data_writedata/data_readdata. It serves CPU loads and stores, with a configurable read latency and sticky error flags for bench checking. It is the standard data-side model for the harvard testbench and for later FPGA bring-up.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_mem_read_pipe.sv | 39 +++
 rtl/mips_harvard_data_mem.sv | 95 +++++++++
 tb/tb_mips_harvard_data_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS Harvard memory responders.
// Both the data-side and instruction-side models import this package.
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } rd_slot_t;

    // Word offset from the region base; byte-lane bits drop out in the shift.
    function automatic logic [ADDR_W-1:0] word_index(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base
    );
        logic [ADDR_W-1:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

endpackage

// File: rtl/mips_mem_read_pipe.sv
// N-stage {valid, data} delay line for load returns; async active-low clear.
// With N=0 it degenerates to wires so the zero-latency path stays combinational.
module mips_mem_read_pipe
    import mips_mem_pkg::*;
#(
    parameter int N = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  rd_slot_t i_slot,
    output rd_slot_t o_slot
);

    generate
        if (N == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst_n;
            assign o_slot   = i_slot;
        end else begin : g_pipe
            rd_slot_t r_stage [N];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < N; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_slot;
                    for (int i = 1; i < N; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_slot = r_stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/mips_harvard_data_mem.sv
// Word-addressed data memory responder for the Harvard CPU data port, with
// configurable read latency and sticky out-of-range / read-write conflict flags.
module mips_harvard_data_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h00000000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_valid,
    output logic        err_oob,
    output logic        err_conflict,
    output logic [15:0] read_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Not reset: bench preload of the array must survive reset.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_rd;
    logic              w_wr;
    logic [DATA_W-1:0] w_word;
    rd_slot_t          w_slot_in;
    rd_slot_t          w_slot_out;

    logic [DATA_W-1:0] r_last;
    logic              r_err_oob;
    logic              r_err_conflict;
    logic [15:0]       r_read_count;

    assign w_idx      = word_index(data_address, BASE_ADDR);
    assign w_in_range = (data_address >= BASE_ADDR) && (w_idx < 32'(DEPTH_WORDS));

    // Requests are ignored while reset is held, so nothing slips through
    // the zero-latency combinational path or the array write port.
    assign w_rd = data_read  & reset;
    assign w_wr = data_write & reset;

    // Array read happens before the edge commits a write: read-before-write.
    assign w_word    = w_in_range ? mem[w_idx[IDX_W-1:0]] : '0;
    assign w_slot_in = '{valid: w_rd, data: w_word};

    always_ff @(posedge clk) begin
        if (w_wr && w_in_range) begin
            mem[w_idx[IDX_W-1:0]] <= data_writedata;
        end
    end

    mips_mem_read_pipe #(
        .N (READ_LATENCY)
    ) u_read_pipe (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_slot  (w_slot_in),
        .o_slot  (w_slot_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last         <= '0;
            r_err_oob      <= 1'b0;
            r_err_conflict <= 1'b0;
            r_read_count   <= '0;
        end else begin
            if (w_slot_out.valid) begin
                r_last       <= w_slot_out.data;
                r_read_count <= r_read_count + 16'd1;
            end
            if ((data_read || data_write) && !w_in_range) begin
                r_err_oob <= 1'b1;
            end
            if (data_read && data_write) begin
                r_err_conflict <= 1'b1;
            end
        end
    end

    // Completed read wins; otherwise hold the last returned word.
    assign data_valid    = w_slot_out.valid;
    assign data_readdata = w_slot_out.valid ? w_slot_out.data : r_last;
    assign err_oob       = r_err_oob;
    assign err_conflict  = r_err_conflict;
    assign read_count    = r_read_count;

endmodule

// File: tb/tb_mips_harvard_data_mem.sv
// Directed bench for mips_harvard_data_mem across several latency/range configs,
// with a scoreboard of expected load data and completion cycle.
module tb_mips_harvard_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [5];
    logic [31:0] addr  [5];
    logic        rd    [5];
    logic        wr    [5];
    logic [31:0] wdata [5];
    logic [31:0] rdata [5];
    logic        vld   [5];
    logic        eoob  [5];
    logic        econf [5];
    logic [15:0] rcnt  [5];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb [$];
    int   n_chk;
    int   n_fail;
    int   cyc_n;
    int   sel;

    mips_harvard_data_mem #(.READ_LATENCY(0)) u_lat0 (
        .clk(clk), .reset(rst_n[0]), .data_address(addr[0]), .data_read(rd[0]),
        .data_write(wr[0]), .data_writedata(wdata[0]), .data_readdata(rdata[0]),
        .data_valid(vld[0]), .err_oob(eoob[0]), .err_conflict(econf[0]), .read_count(rcnt[0]));

    mips_harvard_data_mem #(.READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst_n[1]), .data_address(addr[1]), .data_read(rd[1]),
        .data_write(wr[1]), .data_writedata(wdata[1]), .data_readdata(rdata[1]),
        .data_valid(vld[1]), .err_oob(eoob[1]), .err_conflict(econf[1]), .read_count(rcnt[1]));

    mips_harvard_data_mem #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_n[2]), .data_address(addr[2]), .data_read(rd[2]),
        .data_write(wr[2]), .data_writedata(wdata[2]), .data_readdata(rdata[2]),
        .data_valid(vld[2]), .err_oob(eoob[2]), .err_conflict(econf[2]), .read_count(rcnt[2]));

    mips_harvard_data_mem #(.BASE_ADDR(32'h00001000), .DEPTH_WORDS(16), .READ_LATENCY(0)) u_oob (
        .clk(clk), .reset(rst_n[3]), .data_address(addr[3]), .data_read(rd[3]),
        .data_write(wr[3]), .data_writedata(wdata[3]), .data_readdata(rdata[3]),
        .data_valid(vld[3]), .err_oob(eoob[3]), .err_conflict(econf[3]), .read_count(rcnt[3]));

    mips_harvard_data_mem #(.READ_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst_n[4]), .data_address(addr[4]), .data_read(rd[4]),
        .data_write(wr[4]), .data_writedata(wdata[4]), .data_readdata(rdata[4]),
        .data_valid(vld[4]), .err_oob(eoob[4]), .err_conflict(econf[4]), .read_count(rcnt[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc_n + lat;
        sb.push_back(e);
    endtask

    task automatic drv(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        rd[k]    = r;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    // One clock cycle: sample the selected DUT mid-cycle, then step past the edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (sel >= 0 && vld[sel] === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(vld[sel]), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata[sel], e.data);
                chk("rd_cycle", cyc_n, e.due);
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, "_rdata"}, rdata[k], 32'd0);
        chk({tag, "_valid"}, 32'(vld[k]), 32'd0);
        chk({tag, "_oob"}, 32'(eoob[k]), 32'd0);
        chk({tag, "_conf"}, 32'(econf[k]), 32'd0);
        chk({tag, "_count"}, 32'(rcnt[k]), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc_n  = 0;
        sel    = -1;
        for (int k = 0; k < 5; k++) begin
            rst_n[k] = 1'b0;
            drv(k, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        // Requests while in reset must be ignored.
        drv(0, 1'b1, 1'b1, 32'h10, 32'h12345678);
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) chk_zero("reset", k);
        for (int k = 0; k < 5; k++) begin
            drv(k, 1'b0, 1'b0, 32'h0, 32'h0);
            rst_n[k] = 1'b1;
        end

        // LAT=0 write then same-cycle readback
        sel = 0;
        drv(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        cyc();
        push(32'hDEADBEEF, 0);
        drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        chk("lat0_count", 32'(rcnt[0]), 32'd1);
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("lat0_hold", rdata[0], 32'hDEADBEEF);
        chk("lat0_idle_valid", 32'(vld[0]), 32'd0);
        chk("lat0_sb_empty", 32'(sb.size()), 32'd0);

        // LAT=2 back-to-back reads
        sel = 1;
        for (int i = 0; i < 3; i++) begin
            drv(1, 1'b0, 1'b1, 32'(4 * i), 32'(i + 1));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            push(32'(i + 1), 2);
            drv(1, 1'b1, 1'b0, 32'(4 * i), 32'h0);
            cyc();
        end
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc();
        chk("lat2_sb_empty", 32'(sb.size()), 32'd0);
        chk("lat2_count", 32'(rcnt[1]), 32'd3);
        chk("lat2_hold", rdata[1], 32'd3);

        // LAT=1 read/write collision
        sel = 2;
        drv(2, 1'b0, 1'b1, 32'h20, 32'h11111111);
        cyc();
        chk("coll_conf_before", 32'(econf[2]), 32'd0);
        push(32'h11111111, 1);
        drv(2, 1'b1, 1'b1, 32'h20, 32'h22222222);
        cyc();
        drv(2, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("coll_conf", 32'(econf[2]), 32'd1);
        chk("coll_oob", 32'(eoob[2]), 32'd0);
        push(32'h22222222, 1);
        drv(2, 1'b1, 1'b0, 32'h20, 32'h0);
        cyc();
        drv(2, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        chk("coll_sb_empty", 32'(sb.size()), 32'd0);
        chk("coll_count", 32'(rcnt[2]), 32'd2);

        // Out of range, BASE=0x1000 DEPTH=16
        sel = 3;
        drv(3, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5);
        cyc();
        drv(3, 1'b0, 1'b1, 32'h103C, 32'h5A5A0F0F);
        cyc();
        chk("oob_before", 32'(eoob[3]), 32'd0);
        push(32'h0, 0);
        drv(3, 1'b1, 1'b0, 32'h0FFC, 32'h0);
        cyc();
        chk("oob_read_flag", 32'(eoob[3]), 32'd1);
        drv(3, 1'b0, 1'b1, 32'h1040, 32'hFFFFFFFF);
        cyc();
        push(32'hA5A5A5A5, 0);
        drv(3, 1'b1, 1'b0, 32'h1000, 32'h0);
        cyc();
        push(32'h5A5A0F0F, 0);
        drv(3, 1'b1, 1'b0, 32'h103C, 32'h0);
        cyc();
        drv(3, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("oob_sb_empty", 32'(sb.size()), 32'd0);
        chk("oob_count", 32'(rcnt[3]), 32'd3);
        chk("oob_sticky", 32'(eoob[3]), 32'd1);
        chk("oob_conf", 32'(econf[3]), 32'd0);

        // LAT=3 reset while a read is in flight
        sel = 4;
        drv(4, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        cyc();
        drv(4, 1'b1, 1'b0, 32'h40, 32'h0);
        cyc();
        drv(4, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n[4] = 1'b0;
        cyc();
        chk_zero("midrst1", 4);
        cyc();
        chk_zero("midrst2", 4);
        rst_n[4] = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk_zero("postrst", 4);
        push(32'hCAFEF00D, 3);
        drv(4, 1'b1, 1'b0, 32'h40, 32'h0);
        cyc();
        drv(4, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) cyc();
        chk("lat3_sb_empty", 32'(sb.size()), 32'd0);
        chk("lat3_count", 32'(rcnt[4]), 32'd1);

        // read_count wrap on the LAT=0 instance (count currently 1)
        sel = -1;
        drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 65534; i++) cyc();
        chk("wrap_ffff", 32'(rcnt[0]), 32'h0000FFFF);
        cyc();
        chk("wrap_zero", 32'(rcnt[0]), 32'd0);
        chk("wrap_data", rdata[0], 32'hDEADBEEF);
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("wrap_conf", 32'(econf[0]), 32'd0);
        chk("wrap_oob", 32'(eoob[0]), 32'd0);
        chk("wrap_valid", 32'(vld[0]), 32'd0);
        chk("wrap_hold", 32'(rcnt[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
